// File: rtl/ingress_port_buffer_if.sv
// Port-side bundle for ingress_port_buffer.
// The master modport is the environment: the port interface, the output
// arbiters and the statistics block. The slave modport is the buffer itself.
interface ingress_port_buffer_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Ingress packet beat
  logic                 valid_in;
  logic [NUM_PORTS-1:0] source_in;
  logic [NUM_PORTS-1:0] target_in;
  logic [DATA_W-1:0]    data_in;

  // Crossbar side
  logic [NUM_PORTS-1:0] grant_in;
  logic [NUM_PORTS-1:0] req_out;
  logic                 pkt_valid;
  logic [NUM_PORTS-1:0] pkt_source;
  logic [NUM_PORTS-1:0] pkt_target;
  logic [DATA_W-1:0]    pkt_data;

  // Status and statistics
  logic                 clr_stats;
  logic                 fifo_full;
  logic                 fifo_afull;
  logic [CNT_W-1:0]     fifo_count;
  logic                 drop_pulse;
  logic [15:0]          drop_cnt;

  modport master (
    output valid_in, source_in, target_in, data_in, grant_in, clr_stats,
    input  req_out, pkt_valid, pkt_source, pkt_target, pkt_data,
    input  fifo_full, fifo_afull, fifo_count, drop_pulse, drop_cnt
  );

  modport slave (
    input  valid_in, source_in, target_in, data_in, grant_in, clr_stats,
    output req_out, pkt_valid, pkt_source, pkt_target, pkt_data,
    output fifo_full, fifo_afull, fifo_count, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/ingress_port_buffer.sv
// ingress_port_buffer: per-port ingress stage of the N-port packet switch.
// Single-beat packets are buffered in a DEPTH-entry FIFO (drop on full or on
// a target that is not exactly one-hot). The head packet requests its target
// output, and once granted it is shown to the crossbar for one cycle and then
// popped.
//
// Build option: define INGRESS_DROP_STATS_EN to implement drop_pulse and the
// 16-bit saturating drop_cnt. When it is undefined, both outputs are tied to
// 0 and dropping itself behaves the same.
//
// All outputs come straight from registers. Each register's next value is
// computed from the same-edge push/pop decisions.
module ingress_port_buffer #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input logic                  clk,
  input logic                  rst,
  ingress_port_buffer_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * NUM_PORTS + DATA_W;

  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]     CNT_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_AFULL  = CNT_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0]     PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1'b1);
  localparam logic [NUM_PORTS-1:0] PORTS_ZERO = {NUM_PORTS{1'b0}};
  localparam logic [NUM_PORTS-1:0] PORTS_ONE  = NUM_PORTS'(1'b1);
  localparam logic [ENTRY_W-1:0]   ENTRY_ZERO = {ENTRY_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    logic [NUM_PORTS-1:0] v_minus_one;
    v_minus_one = v - PORTS_ONE;
    return (v != PORTS_ZERO) && ((v & v_minus_one) == PORTS_ZERO);
  endfunction

  // Entry layout: {source, target, data}
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] req_q, req_d;
  logic                 pkt_valid_q, pkt_valid_d;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;

  logic                 tgt_ok_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 drop_s;
  logic [ENTRY_W-1:0]   wr_entry_s;
  logic [NUM_PORTS-1:0] head_tgt_next_s;

  // Push/drop/pop decisions. Push uses the registered count, so a pop at the
  // same edge never makes room for the incoming packet.
  always_comb begin
    tgt_ok_s   = is_onehot(bus.target_in);
    push_s     = bus.valid_in && (count_q < CNT_DEPTH) && tgt_ok_s;
    drop_s     = bus.valid_in && !push_s;
    pop_s      = (state_q == ST_XFER);
    wr_entry_s = {bus.source_in, bus.target_in, bus.data_in};
  end

  // Pointer and occupancy update. Pointers wrap naturally because DEPTH is a
  // power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Next head register: the entry after the popped one, or the incoming
  // packet when it lands in an empty (or just-emptied) FIFO, or zero when
  // the FIFO becomes empty.
  always_comb begin
    head_d = head_q;
    if (pop_s) begin
      if (count_q > CNT_ONE) begin
        head_d = mem_q[rd_ptr_d];
      end else if (push_s) begin
        head_d = wr_entry_s;
      end else begin
        head_d = ENTRY_ZERO;
      end
    end else if (count_q == CNT_ZERO) begin
      if (push_s) begin
        head_d = wr_entry_s;
      end else begin
        head_d = ENTRY_ZERO;
      end
    end else begin
      head_d = head_q;
    end
  end

  // Head FSM next state. Only a grant on the port actually requested counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != CNT_ZERO) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if ((bus.grant_in & req_q) != PORTS_ZERO) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_XFER: begin
        if (count_d != CNT_ZERO) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from next state/head/count.
  always_comb begin
    head_tgt_next_s = head_d[DATA_W +: NUM_PORTS];
    if (state_d == ST_REQ) begin
      req_d = head_tgt_next_s;
    end else begin
      req_d = PORTS_ZERO;
    end
    pkt_valid_d = (state_d == ST_XFER);
    full_d      = (count_d == CNT_DEPTH);
    afull_d     = (count_d >= CNT_AFULL);
  end

  // Control/status registers with synchronous reset. A reset during XFER
  // simply wins over the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      head_q      <= ENTRY_ZERO;
      req_q       <= PORTS_ZERO;
      pkt_valid_q <= 1'b0;
      full_q      <= 1'b0;
      afull_q     <= (CNT_ZERO >= CNT_AFULL);
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      req_q       <= req_d;
      pkt_valid_q <= pkt_valid_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
    end
  end

  // Packet storage. Contents need no reset because the pointers and count
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

`ifdef INGRESS_DROP_STATS_EN
  logic        drop_pulse_q;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Drop counter next value: a clear takes priority, but a drop at the
  // clearing edge is still counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.clr_stats) begin
      if (drop_s) begin
        drop_cnt_d = 16'h0001;
      end else begin
        drop_cnt_d = 16'h0000;
      end
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop statistics registers; the pulse lags the offending edge by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 16'h0000;
    end else begin
      drop_pulse_q <= drop_s;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;
`else
  // Statistics are not built: the drop decision and the clear input are
  // intentionally left without a consumer.
  logic stats_unused_s;
  assign stats_unused_s = drop_s ^ bus.clr_stats;
  assign bus.drop_pulse = 1'b0;
  assign bus.drop_cnt   = 16'h0000;
`endif

  assign bus.req_out    = req_q;
  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.pkt_source = head_q[ENTRY_W-1 -: NUM_PORTS];
  assign bus.pkt_target = head_q[DATA_W +: NUM_PORTS];
  assign bus.pkt_data   = head_q[DATA_W-1:0];
  assign bus.fifo_full  = full_q;
  assign bus.fifo_afull = afull_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_ingress_port_buffer.sv
// Self-checking bench for ingress_port_buffer: a directed vector table,
// hand-written corner sequences and a randomized run. All of them are checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_ingress_port_buffer;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;
`ifdef INGRESS_DROP_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ingress_port_buffer_if #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) bus();
  ingress_port_buffer #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- reference model ----------------
  typedef struct { logic [NP-1:0] src; logic [NP-1:0] tgt; logic [DW-1:0] data; } ent_t;
  ent_t        mq[$];
  int          m_ph;   // 0 idle, 1 requesting, 2 transferring
  logic        m_dp;
  logic [15:0] m_dc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic push, drop, pop;
    int   nph;
    if (rst) begin
      mq.delete(); m_ph = 0; m_dp = 1'b0; m_dc = 16'h0000;
      return;
    end
    push = bus.valid_in && (mq.size() < DEPTH) && $onehot(bus.target_in);
    drop = bus.valid_in && !push;
    pop  = (m_ph == 2);
    nph  = m_ph;
    if (m_ph == 0) nph = (mq.size() > 0) ? 1 : 0;
    else if (m_ph == 1) nph = ((bus.grant_in & mq[0].tgt) != 0) ? 2 : 1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{bus.source_in, bus.target_in, bus.data_in});
    if (m_ph == 2) nph = (mq.size() > 0) ? 1 : 0;
    m_ph = nph;
    m_dp = STATS_EN && drop;
    if (STATS_EN) begin
      if (bus.clr_stats) m_dc = drop ? 16'h0001 : 16'h0000;
      else if (drop && m_dc != 16'hFFFF) m_dc = m_dc + 16'h0001;
    end
  endtask

  task automatic check_model(input string tag);
    logic [NP-1:0] e_req, e_src, e_tgt;
    logic [DW-1:0] e_data;
    e_req  = (m_ph == 1) ? mq[0].tgt : '0;
    e_src  = (mq.size() > 0) ? mq[0].src : '0;
    e_tgt  = (mq.size() > 0) ? mq[0].tgt : '0;
    e_data = (mq.size() > 0) ? mq[0].data : '0;
    chk({tag, ".req"},   bus.req_out,    e_req);
    chk({tag, ".pv"},    bus.pkt_valid,  (m_ph == 2));
    chk({tag, ".src"},   bus.pkt_source, e_src);
    chk({tag, ".tgt"},   bus.pkt_target, e_tgt);
    chk({tag, ".data"},  bus.pkt_data,   e_data);
    chk({tag, ".count"}, bus.fifo_count, mq.size());
    chk({tag, ".full"},  bus.fifo_full,  (mq.size() == DEPTH));
    chk({tag, ".afull"}, bus.fifo_afull, (mq.size() >= AFULL));
    chk({tag, ".dp"},    bus.drop_pulse, m_dp);
    chk({tag, ".dc"},    bus.drop_cnt,   m_dc);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [NP-1:0] s, input logic [NP-1:0] t,
                       input logic [DW-1:0] d, input logic [NP-1:0] g, input logic c);
    bus.valid_in  = v;
    bus.source_in = s;
    bus.target_in = t;
    bus.data_in   = d;
    bus.grant_in  = g;
    bus.clr_stats = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0);
    tick("reset");
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; logic [NP-1:0] t; logic [DW-1:0] d; logic [NP-1:0] g;
    logic [NP-1:0] e_req; logic e_pv; logic [DW-1:0] e_data; logic [3:0] e_cnt;
    logic e_dp; logic [15:0] e_dc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrx, last_t;
    logic [NP-1:0] tg, gr;
    rst = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0);
    #1;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;

    // single packet latency, then two bad targets
    tbl[0] = '{1'b1, 4'b0010, 8'hA5, 4'b0010, 4'b0000, 1'b0, 8'hA5, 4'd1, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 4'b0000, 8'h00, 4'b0010, 4'b0010, 1'b0, 8'hA5, 4'd1, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 4'b0000, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'hA5, 4'd1, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 4'b0000, 8'h00, 4'b0010, 4'b0000, 1'b0, 8'h00, 4'd0, 1'b0, 16'd0};
    tbl[4] = '{1'b1, 4'b0000, 8'hFF, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'd0, STATS_EN, STATS_EN ? 16'd1 : 16'd0};
    tbl[5] = '{1'b1, 4'b0110, 8'h11, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'd0, STATS_EN, STATS_EN ? 16'd2 : 16'd0};
    tbl[6] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'd0, 1'b0, STATS_EN ? 16'd2 : 16'd0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, 4'b0001, tbl[i].t, tbl[i].d, tbl[i].g, 1'b0);
      tick("tbl_model");
      chk($sformatf("tbl[%0d].req", i),   bus.req_out,    tbl[i].e_req);
      chk($sformatf("tbl[%0d].pv", i),    bus.pkt_valid,  tbl[i].e_pv);
      chk($sformatf("tbl[%0d].data", i),  bus.pkt_data,   tbl[i].e_data);
      chk($sformatf("tbl[%0d].count", i), bus.fifo_count, tbl[i].e_cnt);
      chk($sformatf("tbl[%0d].dp", i),    bus.drop_pulse, tbl[i].e_dp);
      chk($sformatf("tbl[%0d].dc", i),    bus.drop_cnt,   tbl[i].e_dc);
    end

    // overflow: 17 back-to-back packets with no grant
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 4'b0001, 4'b0010, 8'(i), 4'b0000, 1'b0);
      tick("ovf_fill");
      if (i == 7) chk("ovf_full_after_8", bus.fifo_full, 1'b1);
    end
    chk("ovf_count", bus.fifo_count, 4'd8);
    chk("ovf_dropcnt", bus.drop_cnt, STATS_EN ? 16'd9 : 16'd0);
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0010, 1'b0);
    nrx = 0; last_t = 0;
    for (int c = 0; c < 24; c++) begin
      tick("ovf_drain");
      if (bus.pkt_valid) begin
        chk("ovf_order", bus.pkt_data, nrx);
        if (nrx > 0) chk("ovf_gap", c - last_t, 2);
        last_t = c;
        nrx++;
      end
    end
    chk("ovf_drained", nrx, 8);
    chk("ovf_empty", bus.fifo_count, 4'd0);

    // grant to a non-requested port is ignored
    do_reset();
    drive(1'b1, 4'b0100, 4'b1000, 8'h3C, 4'b0100, 1'b0);
    tick("gnt_push");
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0100, 1'b0);
    tick("gnt_wrong0");
    tick("gnt_wrong1");
    tick("gnt_wrong2");
    chk("gnt_wrong_req", bus.req_out, 4'b1000);
    chk("gnt_wrong_pv", bus.pkt_valid, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b1000, 1'b0);
    tick("gnt_right");
    chk("gnt_right_pv", bus.pkt_valid, 1'b1);
    chk("gnt_right_data", bus.pkt_data, 8'h3C);
    tick("gnt_pop");

    // push during XFER while full: dropped, count DEPTH -> DEPTH-1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0010, 4'b0001, 8'(8'h40 + i), 4'b0000, 1'b0);
      tick("full_fill");
    end
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0001, 1'b0);
    tick("full_xfer");
    chk("full_xfer_pv", bus.pkt_valid, 1'b1);
    chk("full_xfer_cnt", bus.fifo_count, 4'd8);
    drive(1'b1, 4'b0010, 4'b0001, 8'hEE, 4'b0001, 1'b0);
    tick("full_pushpop");
    chk("full_pushpop_cnt", bus.fifo_count, 4'd7);
    chk("full_pushpop_dp", bus.drop_pulse, STATS_EN);

    // push+pop at count 3 keeps count at 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 4'b0100, 8'(8'h70 + i), 4'b0000, 1'b0);
      tick("c3_fill");
    end
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0100, 1'b0);
    tick("c3_xfer");
    chk("c3_xfer_pv", bus.pkt_valid, 1'b1);
    drive(1'b1, 4'b0001, 4'b0100, 8'h77, 4'b0100, 1'b0);
    tick("c3_pushpop");
    chk("c3_pushpop_cnt", bus.fifo_count, 4'd3);

    // reset in XFER abandons the transfer
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0100, 1'b0);
    tick("rx_xfer");
    chk("rx_xfer_pv", bus.pkt_valid, 1'b1);
    rst = 1'b1;
    tick("rx_rst");
    rst = 1'b0;
    chk("rx_rst_cnt", bus.fifo_count, 4'd0);
    chk("rx_rst_pv", bus.pkt_valid, 1'b0);
    tick("rx_after");
    chk("rx_after_pv", bus.pkt_valid, 1'b0);

    // clear coinciding with a drop leaves a count of one
    drive(1'b1, 4'b0001, 4'b0000, 8'h00, 4'b0000, 1'b0);
    tick("clr_drop0");
    tick("clr_drop1");
    drive(1'b1, 4'b0001, 4'b0000, 8'h00, 4'b0000, 1'b1);
    tick("clr_drop2");
    chk("clr_with_drop", bus.drop_cnt, STATS_EN ? 16'd1 : 16'd0);

    // saturation of the drop counter
    drive(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0);
`ifdef INGRESS_DROP_STATS_EN
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    m_dc = 16'hFFFE;
`endif
    drive(1'b1, 4'b0001, 4'b1111, 8'h00, 4'b0000, 1'b0);
    tick("sat0");
    tick("sat1");
    tick("sat2");
    chk("sat_dropcnt", bus.drop_cnt, STATS_EN ? 16'hFFFF : 16'h0000);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) tg = NP'(1) << (r % 4);
      else if (r == 8) tg = 4'b0000;
      else tg = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      gr = (r == 0) ? 4'b0000 : (NP'(1) << $urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), tg,
            8'($urandom_range(0, 255)), gr, ($urandom_range(0, 31) == 0));
      rst = ($urandom_range(0, 199) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
